// File: rtl/pcie_bram_wr_ctrl.sv
// PCIe-to-BRAM write controller: drains complete TLPs from a non-FWFT FIFO
// into a registered BRAM write port; local user writes run when PCIe is idle.
`ifndef BRAM_DATA_WIDTH
`define BRAM_DATA_WIDTH 32
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 16
`endif
`ifndef BRAM_KEEP_WIDTH
`define BRAM_KEEP_WIDTH 4
`endif
`ifndef FIFO_DATA_WIDTH
`define FIFO_DATA_WIDTH (`BRAM_KEEP_WIDTH + `BRAM_ADDR_WIDTH + `BRAM_DATA_WIDTH)
`endif

module pcie_bram_wr_ctrl #(
   parameter int unsigned MAX_WORDS   = 256,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         MEM_WR_REQ,
   output logic                         MEM_WR_ACK,
   output logic                         FIFO_RD_EN,
   input  logic [`FIFO_DATA_WIDTH-1:0]  FIFO_RD_DATA,
   input  logic                         FIFO_RD_EMPTY,
   input  logic                         USR_WR_REQ,
   input  logic [`BRAM_ADDR_WIDTH-1:0]  USR_WR_ADDR,
   input  logic [`BRAM_DATA_WIDTH-1:0]  USR_WR_DATA,
   input  logic [`BRAM_KEEP_WIDTH-1:0]  USR_WR_KEEP,
   output logic                         USR_WR_GNT,
   output logic                         BRAM_EN,
   output logic [`BRAM_KEEP_WIDTH-1:0]  BRAM_WE,
   output logic [`BRAM_ADDR_WIDTH-1:0]  BRAM_ADDR,
   output logic [`BRAM_DATA_WIDTH-1:0]  BRAM_DIN,
   output logic [8:0]                   WORD_CNT,
   output logic                         BUSY,
   output logic                         ERR_TIMEOUT
);

   localparam int unsigned DW  = `BRAM_DATA_WIDTH;
   localparam int unsigned AW  = `BRAM_ADDR_WIDTH;
   localparam int unsigned KW  = `BRAM_KEEP_WIDTH;
   localparam int unsigned PCW = $clog2(MAX_WORDS + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PCW-1:0] POP_MAX   = PCW'(MAX_WORDS);
   localparam logic [TCW-1:0] IDLE_LAST = TCW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH,
      ACK
   } state_t;

   state_t           state_q, state_d;
   logic [PCW-1:0]   pop_cnt_q, pop_cnt_d;
   logic [TCW-1:0]   idle_q, idle_d;
   logic [8:0]       wr_cnt_q, wr_cnt_d;
   logic [8:0]       word_cnt_q;
   logic             pop_dly_q;
   logic             hold_q;
   logic             err_q;
   logic             gnt_q;
   logic             bram_en_q;
   logic [KW-1:0]    bram_we_q;
   logic [AW-1:0]    bram_addr_q;
   logic [DW-1:0]    bram_din_q;

   logic             rd_en;
   logic             usr_go;
   logic             clr_cnt;
   logic             timeout;

   // Pops are counted when issued (pop_cnt) so the MAX_WORDS cap is exact even
   // though the matching BRAM write, and wr_cnt, land one cycle later.
   always_comb begin
      state_d   = state_q;
      pop_cnt_d = pop_cnt_q;
      idle_d    = idle_q;
      rd_en     = 1'b0;
      usr_go    = 1'b0;
      clr_cnt   = 1'b0;
      timeout   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (MEM_WR_REQ && !hold_q) begin
               state_d   = DRAIN;
               pop_cnt_d = '0;
               idle_d    = '0;
               clr_cnt   = 1'b1;
            end else if (!MEM_WR_REQ && USR_WR_REQ) begin
               usr_go = 1'b1;
            end
         end
         DRAIN: begin
            rd_en = !FIFO_RD_EMPTY && (pop_cnt_q < POP_MAX);
            if (rd_en) pop_cnt_d = pop_cnt_q + PCW'(1);
            if (pop_cnt_q == POP_MAX) begin
               state_d = FLUSH;
            end else if (FIFO_RD_EMPTY) begin
               if (pop_cnt_q != '0) begin
                  state_d = FLUSH;
               end else if (idle_q == IDLE_LAST) begin
                  timeout = 1'b1;
                  state_d = ACK;
               end else begin
                  idle_d = idle_q + TCW'(1);
               end
            end
         end
         FLUSH:   state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (clr_cnt) wr_cnt_d = '0;
      else if (pop_dly_q && (wr_cnt_q != 9'h1FF)) wr_cnt_d = wr_cnt_q + 9'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         pop_cnt_q  <= '0;
         idle_q     <= '0;
         wr_cnt_q   <= '0;
         word_cnt_q <= '0;
         pop_dly_q  <= 1'b0;
         hold_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pop_cnt_q  <= pop_cnt_d;
         idle_q     <= idle_d;
         wr_cnt_q   <= wr_cnt_d;
         pop_dly_q  <= rd_en;
         // Blocks re-entry in the cycle after ACK while the requester drops MEM_WR_REQ.
         hold_q     <= (state_q == ACK);
         err_q      <= err_q | timeout;
         if (state_q == ACK) word_cnt_q <= wr_cnt_q;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gnt_q       <= 1'b0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= '0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
      end else begin
         gnt_q     <= usr_go;
         bram_en_q <= 1'b0;
         bram_we_q <= '0;
         if (pop_dly_q) begin
            bram_en_q   <= 1'b1;
            bram_we_q   <= FIFO_RD_DATA[DW+AW+KW-1:DW+AW];
            bram_addr_q <= FIFO_RD_DATA[DW+AW-1:DW];
            bram_din_q  <= FIFO_RD_DATA[DW-1:0];
         end else if (usr_go) begin
            bram_en_q   <= 1'b1;
            bram_we_q   <= USR_WR_KEEP;
            bram_addr_q <= USR_WR_ADDR;
            bram_din_q  <= USR_WR_DATA;
         end
      end
   end

   assign MEM_WR_ACK  = (state_q == ACK);
   assign BUSY        = (state_q != IDLE);
   assign FIFO_RD_EN  = rd_en;
   assign USR_WR_GNT  = gnt_q;
   assign BRAM_EN     = bram_en_q;
   assign BRAM_WE     = bram_we_q;
   assign BRAM_ADDR   = bram_addr_q;
   assign BRAM_DIN    = bram_din_q;
   assign WORD_CNT    = word_cnt_q;
   assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_pcie_bram_wr_ctrl.sv
// Scoreboard bench for pcie_bram_wr_ctrl: behavioural non-FWFT FIFO, expected
// BRAM writes queued at stimulus time and compared against observed writes.
`ifndef BRAM_DATA_WIDTH
`define BRAM_DATA_WIDTH 32
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 16
`endif
`ifndef BRAM_KEEP_WIDTH
`define BRAM_KEEP_WIDTH 4
`endif
`ifndef FIFO_DATA_WIDTH
`define FIFO_DATA_WIDTH (`BRAM_KEEP_WIDTH + `BRAM_ADDR_WIDTH + `BRAM_DATA_WIDTH)
`endif

module tb_pcie_bram_wr_ctrl;

   localparam int FW = `FIFO_DATA_WIDTH;
   localparam int DW = `BRAM_DATA_WIDTH;
   localparam int AW = `BRAM_ADDR_WIDTH;
   localparam int KW = `BRAM_KEEP_WIDTH;
   typedef logic [FW-1:0] word_t;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          MEM_WR_REQ;
   logic          MEM_WR_ACK;
   logic          FIFO_RD_EN;
   word_t         fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          USR_WR_REQ;
   logic [AW-1:0] USR_WR_ADDR;
   logic [DW-1:0] USR_WR_DATA;
   logic [KW-1:0] USR_WR_KEEP;
   logic          USR_WR_GNT;
   logic          BRAM_EN;
   logic [KW-1:0] BRAM_WE;
   logic [AW-1:0] BRAM_ADDR;
   logic [DW-1:0] BRAM_DIN;
   logic [8:0]    WORD_CNT;
   logic          BUSY;
   logic          ERR_TIMEOUT;

   int checks = 0;
   int errors = 0;

   word_t fifo_q[$];
   word_t exp_q[$];
   word_t obs_q[$];
   int    pop_cyc_q[$];
   int    cyc = 0;
   int    ack_cnt = 0;
   int    gnt_cnt = 0;
   bit    rd_bad = 0;
   bit    we_bad = 0;

   pcie_bram_wr_ctrl #(.MAX_WORDS(256), .TIMEOUT_CYC(1024)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .MEM_WR_REQ(MEM_WR_REQ), .MEM_WR_ACK(MEM_WR_ACK),
      .FIFO_RD_EN(FIFO_RD_EN), .FIFO_RD_DATA(fifo_dout), .FIFO_RD_EMPTY(fifo_empty),
      .USR_WR_REQ(USR_WR_REQ), .USR_WR_ADDR(USR_WR_ADDR), .USR_WR_DATA(USR_WR_DATA),
      .USR_WR_KEEP(USR_WR_KEEP), .USR_WR_GNT(USR_WR_GNT),
      .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN),
      .WORD_CNT(WORD_CNT), .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   // Non-FWFT FIFO: data one cycle after the pop, empty flag registered.
   always @(posedge CLK) begin
      if (FIFO_RD_EN) begin
         if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
         else rd_bad = 1;
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (BRAM_EN) obs_q.push_back({BRAM_WE, BRAM_ADDR, BRAM_DIN});
      if (!BRAM_EN && BRAM_WE != '0) we_bad = 1;
      if (FIFO_RD_EN) pop_cyc_q.push_back(cyc);
      if (FIFO_RD_EN && (fifo_empty || !BUSY)) rd_bad = 1;
      if (MEM_WR_ACK) ack_cnt = ack_cnt + 1;
      if (USR_WR_GNT) gnt_cnt = gnt_cnt + 1;
   end

   task automatic load_word(input logic [KW-1:0] k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit expect_wr);
      fifo_q.push_back({k, a, d});
      if (expect_wr) exp_q.push_back({k, a, d});
   endtask

   task automatic wait_ack(input int budget, output bit seen, output int cycles);
      seen = 0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge CLK);
         cycles++;
         if (MEM_WR_ACK) seen = 1;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b1;
      #3 RST_N = 1'b0;
      #1;
      checks++;
      if ({MEM_WR_ACK, FIFO_RD_EN, USR_WR_GNT, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN,
           WORD_CNT, BUSY, ERR_TIMEOUT} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got en=%b we=%h addr=%h din=%h cnt=%0d busy=%b err=%b want all 0",
                  BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, WORD_CNT, BUSY, ERR_TIMEOUT);
      end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b want 0", BUSY);
      end
   endtask

   task automatic test_basic();
      bit seen;
      int n, a0;
      word_t e, o;
      a0 = ack_cnt;
      pop_cyc_q.delete();
      @(negedge CLK);
      for (int i = 0; i < 4; i++)
         load_word((i == 2) ? 4'b0101 : 4'b1111, AW'(16'h10 + i), DW'(32'hA0B0_0000 + i), 1);
      MEM_WR_REQ = 1'b1;
      wait_ack(40, seen, n);
      checks++;
      if (!seen) begin errors++; $display("FAIL basic_ack got none want pulse within 40"); end
      @(negedge CLK);
      checks++;
      if (MEM_WR_ACK !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic_no_reentry got ack=%b busy=%b want 0 0", MEM_WR_ACK, BUSY);
      end
      MEM_WR_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (WORD_CNT !== 9'd4) begin errors++; $display("FAIL basic_word_cnt got %0d want 4", WORD_CNT); end
      checks++;
      if (ack_cnt - a0 != 1) begin errors++; $display("FAIL basic_ack_count got %0d want 1", ack_cnt - a0); end
      checks++;
      if (pop_cyc_q.size() != 4 || pop_cyc_q[3] - pop_cyc_q[0] != 3) begin
         errors++;
         $display("FAIL basic_pops got %0d pops want 4 consecutive", pop_cyc_q.size());
      end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL basic_wr%0d got %h want %h", n, o, e); end
         n++;
      end
      checks++;
      if (n != 4 || exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL basic_wr_count got %0d extra_obs=%0d want 4 0", n, obs_q.size());
      end
   endtask

   task automatic test_priority();
      bit seen;
      int n, g0;
      word_t e, o;
      g0 = gnt_cnt;
      @(negedge CLK);
      load_word(4'b0011, 16'h0020, 32'h1111_2222, 1);
      load_word(4'b1100, 16'h0021, 32'h3333_4444, 1);
      USR_WR_ADDR = 16'h0055;
      USR_WR_DATA = 32'hDEAD_BEEF;
      USR_WR_KEEP = 4'b1001;
      exp_q.push_back({4'b1001, 16'h0055, 32'hDEAD_BEEF});
      MEM_WR_REQ = 1'b1;
      USR_WR_REQ = 1'b1;
      wait_ack(40, seen, n);
      checks++;
      if (!seen) begin errors++; $display("FAIL prio_ack got none want pulse"); end
      checks++;
      if (gnt_cnt != g0) begin errors++; $display("FAIL prio_early_gnt got %0d grants want 0", gnt_cnt - g0); end
      @(negedge CLK);
      MEM_WR_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (USR_WR_GNT !== 1'b1) begin errors++; $display("FAIL prio_gnt got %b want 1", USR_WR_GNT); end
      USR_WR_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (gnt_cnt - g0 != 1) begin errors++; $display("FAIL prio_gnt_count got %0d want 1", gnt_cnt - g0); end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL prio_wr%0d got %h want %h", n, o, e); end
         n++;
      end
      checks++;
      if (n != 3 || exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL prio_wr_count got %0d want 3", n);
      end
   endtask

   task automatic test_back_to_back();
      int n, g0;
      word_t e, o;
      g0 = gnt_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         USR_WR_REQ  = 1'b1;
         USR_WR_ADDR = AW'(16'h0300 + i);
         USR_WR_DATA = $urandom;
         USR_WR_KEEP = KW'($urandom_range(1, 15));
         exp_q.push_back({USR_WR_KEEP, USR_WR_ADDR, USR_WR_DATA});
      end
      @(negedge CLK);
      USR_WR_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (gnt_cnt - g0 != 3) begin errors++; $display("FAIL b2b_gnt_count got %0d want 3", gnt_cnt - g0); end
      n = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL b2b_wr%0d got %h want %h", n, o, e); end
         n++;
      end
      checks++;
      if (n != 3 || exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_wr_count got %0d want 3", n);
      end
   endtask

   task automatic test_max_words();
      bit seen;
      int n;
      word_t e, o;
      @(negedge CLK);
      for (int i = 0; i < 300; i++)
         load_word(KW'($urandom_range(0, 15)), AW'(16'h1000 + i), $urandom, 1);
      for (int round = 0; round < 2; round++) begin
         MEM_WR_REQ = 1'b1;
         wait_ack(400, seen, n);
         checks++;
         if (!seen) begin errors++; $display("FAIL max_ack%0d got none want pulse", round); end
         @(negedge CLK);
         MEM_WR_REQ = 1'b0;
         @(negedge CLK);
         checks++;
         if (WORD_CNT !== ((round == 0) ? 9'd256 : 9'd44)) begin
            errors++;
            $display("FAIL max_word_cnt%0d got %0d want %0d", round, WORD_CNT, (round == 0) ? 256 : 44);
         end
         n = 0;
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL max_wr%0d_%0d got %h want %h", round, n, o, e); end
            n++;
         end
         checks++;
         if (n != ((round == 0) ? 256 : 44) || obs_q.size() != 0) begin
            errors++;
            $display("FAIL max_wr_count%0d got %0d want %0d", round, n, (round == 0) ? 256 : 44);
         end
         repeat (2) @(negedge CLK);
      end
      checks++;
      if (exp_q.size() != 0 || fifo_q.size() != 0) begin
         errors++;
         $display("FAIL max_leftover got exp=%0d fifo=%0d want 0 0", exp_q.size(), fifo_q.size());
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int n;
      @(negedge CLK);
      MEM_WR_REQ = 1'b1;
      wait_ack(1100, seen, n);
      checks++;
      if (!seen || n < 1024 || n > 1026) begin
         errors++;
         $display("FAIL timeout_ack got seen=%b after %0d cycles want ~1025", seen, n);
      end
      @(negedge CLK);
      MEM_WR_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (ERR_TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", ERR_TIMEOUT); end
      checks++;
      if (WORD_CNT !== 9'd0) begin errors++; $display("FAIL timeout_word_cnt got %0d want 0", WORD_CNT); end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL timeout_writes got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_sticky_err();
      @(negedge CLK);
      load_word(4'b0110, 16'h0042, 32'h0BAD_F00D, 1);
      MEM_WR_REQ = 1'b1;
      repeat (8) @(negedge CLK);
      MEM_WR_REQ = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if (ERR_TIMEOUT !== 1'b1) begin errors++; $display("FAIL sticky_err got %b want 1", ERR_TIMEOUT); end
      checks++;
      if (WORD_CNT !== 9'd1 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL sticky_xfer got cnt=%0d writes=%0d want 1 1", WORD_CNT, obs_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_drain();
      int a0;
      a0 = ack_cnt;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) load_word(4'b1111, AW'(16'h0500 + i), $urandom, 0);
      MEM_WR_REQ = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", BUSY); end
      RST_N = 1'b0;
      MEM_WR_REQ = 1'b0;
      #1;
      checks++;
      if ({MEM_WR_ACK, FIFO_RD_EN, USR_WR_GNT, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN,
           WORD_CNT, BUSY, ERR_TIMEOUT} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got en=%b rd=%b busy=%b err=%b cnt=%0d want all 0",
                  BRAM_EN, FIFO_RD_EN, BUSY, ERR_TIMEOUT, WORD_CNT);
      end
      fifo_q.delete();
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || ack_cnt != a0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_abandon got busy=%b acks=%0d writes=%0d want 0 0 0",
                  BUSY, ack_cnt - a0, obs_q.size());
      end
   endtask

   initial begin
      MEM_WR_REQ  = 1'b0;
      USR_WR_REQ  = 1'b0;
      USR_WR_ADDR = '0;
      USR_WR_DATA = '0;
      USR_WR_KEEP = '0;
      test_reset();
      test_basic();
      test_priority();
      test_back_to_back();
      test_max_words();
      test_timeout();
      test_sticky_err();
      test_reset_mid_drain();
      checks++;
      if (rd_bad || we_bad) begin
         errors++;
         $display("FAIL protocol got rd_bad=%b we_bad=%b want 0 0", rd_bad, we_bad);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_bram_wr_ctrl.md
PCIE_BRAM_WR_CTRL -- requirements
Module: pcie_bram_wr_ctrl

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum FIFO words drained per request before a forced ACK.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the idle-empty cycles tolerated while draining before abort.
REQ-003 SHALL have port CLK  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port MEM_WR_REQ  in  1  level request: a complete TLP is resident in the TLP FIFO.
REQ-006 SHALL have port MEM_WR_ACK  out  1  one-cycle pulse: the request is serviced.
REQ-007 SHALL have port FIFO_RD_EN  out  1  FIFO pop.
REQ-008 SHALL have port FIFO_RD_DATA  in  `FIFO_DATA_WIDTH  {keep, addr, data}, valid 1 cycle after a pop (non-FWFT).
REQ-009 SHALL have port FIFO_RD_EMPTY  in  1  FIFO empty.
REQ-010 SHALL have port USR_WR_REQ  in  1  local write request.
REQ-011 SHALL have ports USR_WR_ADDR / USR_WR_DATA / USR_WR_KEEP  in  `BRAM_ADDR_WIDTH / `BRAM_DATA_WIDTH / `BRAM_KEEP_WIDTH  local write payload.
REQ-012 SHALL have port USR_WR_GNT  out  1  one-cycle pulse: local write performed this cycle.
REQ-013 SHALL have ports BRAM_EN  out  1, BRAM_WE  out  `BRAM_KEEP_WIDTH, BRAM_ADDR  out  `BRAM_ADDR_WIDTH, BRAM_DIN  out  `BRAM_DATA_WIDTH  BRAM write port, all registered.
REQ-014 SHALL have port WORD_CNT  out  9  words written for the last serviced request.
REQ-015 SHALL have ports BUSY  out  1  (state != IDLE) and ERR_TIMEOUT  out  1  (sticky abort flag).

Function
REQ-016 SHALL implement states IDLE, DRAIN, FLUSH, ACK.
REQ-017 In IDLE with MEM_WR_REQ=1 SHALL enter DRAIN, clear the word counter, and ignore USR_WR_REQ (PCIe priority).
REQ-018 In IDLE with MEM_WR_REQ=0 and USR_WR_REQ=1 SHALL write the user payload: BRAM_EN=1, BRAM_WE=USR_WR_KEEP, and USR_WR_GNT pulse on the same registered cycle; one write per cycle while the request is held.
REQ-019 In DRAIN SHALL assert FIFO_RD_EN = ~FIFO_RD_EMPTY & (count < MAX_WORDS), one pop per cycle sustained.
REQ-020 One cycle after each pop SHALL register BRAM_EN=1, BRAM_WE=keep field, BRAM_ADDR=addr field, BRAM_DIN=data field, and increment the count (saturating at 511).
REQ-021 Fields SHALL decode as data=[`BRAM_DATA_WIDTH-1:0], addr=next `BRAM_ADDR_WIDTH bits, keep=top `BRAM_KEEP_WIDTH bits.
REQ-022 DRAIN SHALL go to FLUSH when FIFO_RD_EMPTY=1 after at least one pop, or when count reaches MAX_WORDS.
REQ-023 FLUSH SHALL last exactly one cycle to retire the in-flight read, then go to ACK.
REQ-024 ACK SHALL pulse MEM_WR_ACK for one cycle, latch WORD_CNT, and return to IDLE; the controller SHALL NOT re-enter DRAIN on the following cycle even if MEM_WR_REQ is still 1 (it deasserts one cycle after the ACK).
REQ-025 In DRAIN with FIFO_RD_EMPTY=1 and no pop yet, SHALL count idle cycles; at TIMEOUT_CYC it SHALL set ERR_TIMEOUT and go to ACK with WORD_CNT=0.
REQ-026 BRAM_EN/BRAM_WE SHALL be 0 in every cycle without a FIFO word or user grant; BRAM_WE SHALL never be nonzero while BRAM_EN=0.
REQ-027 FIFO_RD_EN SHALL never be asserted while FIFO_RD_EMPTY=1 or outside DRAIN.
REQ-028 USR_WR_REQ arriving mid-DRAIN SHALL wait; it is granted in the first IDLE cycle with MEM_WR_REQ=0.

Reset
REQ-029 On RST_N=0 SHALL force, asynchronously: state IDLE, MEM_WR_ACK=0, FIFO_RD_EN=0, USR_WR_GNT=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0, WORD_CNT=0, BUSY=0, ERR_TIMEOUT=0.
REQ-030 Reset asserted mid-DRAIN SHALL abandon the transfer with no ACK; the popped word SHALL NOT be written.
REQ-031 ERR_TIMEOUT SHALL clear only by reset.

Verification
REQ-032 FIFO preloaded with 4 words (addr 0x10..0x13), MEM_WR_REQ=1 -> 4 pops on consecutive cycles, 4 BRAM writes with matching addr/data/keep, one ACK pulse, WORD_CNT=4.
REQ-033 USR_WR_REQ and MEM_WR_REQ rise on the same cycle -> DRAIN first; USR_WR_GNT only after ACK and MEM_WR_REQ drop.
REQ-034 MEM_WR_REQ=1, FIFO empty for 1024 cycles -> ERR_TIMEOUT=1, ACK pulse, WORD_CNT=0, zero BRAM writes.
REQ-035 FIFO holding 300 words, MAX_WORDS=256 -> exactly 256 writes, ACK, WORD_CNT=256; remaining 44 drained on the next request.
REQ-036 RST_N low on the 2nd DRAIN cycle -> all outputs zero immediately, no ACK, returns to IDLE after release.
REQ-037 Keep field 0b0101 on a word -> BRAM_WE=0b0101 on that write cycle.
